// File: rtl/debug_cmd_sequencer.sv
// debug_cmd_sequencer: decodes UART debug commands, sequences load/run/step and returns ACK/NAK or a PC+cycle dump
module debug_cmd_sequencer #(
  parameter int UART_BITS = 8,
  parameter int PC_BITS = 32,
  parameter int CYCLE_BITS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rx_done,
  input  logic [UART_BITS-1:0] i_rx_data,
  input  logic i_tx_done,
  output logic o_tx_start,
  output logic [UART_BITS-1:0] o_tx_data,
  output logic o_load_start,
  input  logic i_load_done,
  output logic o_cpu_enable,
  input  logic i_halt,
  input  logic [PC_BITS-1:0] i_pc,
  output logic o_busy
);
  localparam int SW = PC_BITS + CYCLE_BITS;
  localparam int NB = SW / UART_BITS;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);
  localparam logic [UART_BITS-1:0] CMD_L = 'h4C;
  localparam logic [UART_BITS-1:0] CMD_R = 'h52;
  localparam logic [UART_BITS-1:0] CMD_S = 'h53;
  localparam logic [UART_BITS-1:0] ACK = 'h06;
  localparam logic [UART_BITS-1:0] NAK = 'h15;
  typedef enum logic [2:0] {IDLE, LOAD_START, LOAD_WAIT, RUN, STEP, DUMP, REPLY} state_t;
  state_t state, state_nxt;
  logic [CYCLE_BITS-1:0] cnt, cnt_nxt;
  logic [SW-1:0] sh;
  logic [IW-1:0] idx;
  logic tx_wait, byte_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (i_rx_done) state_nxt = i_rx_data == CMD_L ? LOAD_START :
                                             i_rx_data == CMD_R ? RUN :
                                             i_rx_data == CMD_S ? STEP : REPLY;
      LOAD_START: state_nxt = LOAD_WAIT;
      LOAD_WAIT:  if (i_load_done) state_nxt = REPLY;
      RUN:        if (i_halt) state_nxt = DUMP;
      STEP:       state_nxt = DUMP;
      DUMP:       if (byte_done && idx == LAST) state_nxt = IDLE;
      REPLY:      if (byte_done) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    o_busy = state != IDLE;
    o_load_start = state == LOAD_START;
    o_cpu_enable = (state == RUN || state == STEP) && !i_halt;
    o_tx_start = (state == DUMP || state == REPLY) && !tx_wait;
    o_tx_data = sh[SW-1 -: UART_BITS];
    byte_done = tx_wait && i_tx_done;
    cnt_nxt = state == LOAD_START ? '0 : cnt + CYCLE_BITS'(o_cpu_enable);
  end
  // the shift register doubles as the tx holding register: dump snapshot or the reply byte sits in its top byte
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sh <= '0;
      idx <= '0;
      tx_wait <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      tx_wait <= o_tx_start || (tx_wait && !i_tx_done);
      idx <= state == DUMP ? idx + IW'(byte_done) : '0;
      if (state_nxt == DUMP && state != DUMP) sh <= {i_pc, cnt_nxt};
      else if (state_nxt == REPLY && state != REPLY) sh <= {state == IDLE ? NAK : ACK, {(SW-UART_BITS){1'b0}}};
      else if (state == DUMP && byte_done) sh <= sh << UART_BITS;
    end
endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// tb_debug_cmd_sequencer: scoreboard bench for the debug command sequencer
module tb_debug_cmd_sequencer;
  logic clk = 0, rst = 0, i_rx_done = 0, i_tx_done = 0, i_load_done = 0, i_halt = 0;
  logic [7:0] i_rx_data = 0;
  logic [31:0] i_pc = 0;
  logic o_tx_start, o_load_start, o_cpu_enable, o_busy;
  logic [7:0] o_tx_data;
  logic [7:0] exp_q[$];
  logic [7:0] e;
  int pass_cnt = 0, total = 0, en_cnt = 0, ls_cnt = 0, dly = 0;
  bit in_flight = 0;
  logic [31:0] mcnt = 0;

  debug_cmd_sequencer dut (
    .clk(clk), .rst(rst), .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_tx_done(i_tx_done),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_load_start(o_load_start),
    .i_load_done(i_load_done), .o_cpu_enable(o_cpu_enable), .i_halt(i_halt), .i_pc(i_pc), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // tx byte monitor plus a UART-transmitter stand-in with random per-byte latency
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 0;
      i_tx_done = 0;
    end else begin
      if (o_cpu_enable) en_cnt++;
      if (o_load_start) ls_cnt++;
      i_tx_done = 0;
      if (o_tx_start) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL tx_unexpected got=%h", o_tx_data);
        else begin
          e = exp_q.pop_front();
          if (in_flight || o_tx_data !== e) $display("FAIL tx_byte got=%h overlap=%0d exp=%h", o_tx_data, in_flight, e);
          else pass_cnt++;
        end
      end
      if (in_flight) begin
        if (dly == 0) begin i_tx_done = 1; in_flight = 0; end
        else dly--;
      end else if (o_tx_start) begin
        in_flight = 1;
        dly = $urandom_range(0, 3);
      end
    end
  end

  task automatic push64(input logic [63:0] v);
    for (int i = 0; i < 8; i++) exp_q.push_back(v[63-8*i -: 8]);
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_done = 1;
    i_rx_data = b;
    @(posedge clk); #1;
    i_rx_done = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while ((o_busy || exp_q.size() != 0) && n < lim);
  endtask

  task automatic do_load();
    exp_q.push_back(8'h06);
    send_rx(8'h4C);
    repeat (2) @(posedge clk);
    #1 i_load_done = 1;
    @(posedge clk); #1 i_load_done = 0;
    wait_idle(200);
    mcnt = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    total++;
    if ({o_tx_start, o_tx_data, o_load_start, o_cpu_enable, o_busy} !== 12'h0)
      $display("FAIL reset_outputs got=%b exp=0", {o_tx_start, o_tx_data, o_load_start, o_cpu_enable, o_busy});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_load();
    exp_q.push_back(8'h06);
    send_rx(8'h4C);
    total++;
    if (o_load_start !== 1'b1 || o_busy !== 1'b1) $display("FAIL load_pulse got=%b%b exp=11", o_load_start, o_busy);
    else pass_cnt++;
    @(posedge clk); #1;
    total++;
    if (o_load_start !== 1'b0 || o_busy !== 1'b1) $display("FAIL load_pulse_len got=%b%b exp=01", o_load_start, o_busy);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1 i_load_done = 1;
    @(posedge clk); #1 i_load_done = 0;
    wait_idle(200);
    total++;
    if (o_busy !== 1'b0 || exp_q.size() != 0) $display("FAIL load_ack busy=%b pending=%0d exp=0/0", o_busy, exp_q.size());
    else pass_cnt++;
    mcnt = 0;
  endtask

  task automatic test_nak();
    int en0 = en_cnt, ls0 = ls_cnt;
    exp_q.push_back(8'h15);
    send_rx(8'h7A);
    wait_idle(200);
    total++;
    if (o_busy !== 1'b0 || exp_q.size() != 0 || en_cnt != en0 || ls_cnt != ls0)
      $display("FAIL nak busy=%b pending=%0d en=%0d ls=%0d exp=0/0/0/0", o_busy, exp_q.size(), en_cnt - en0, ls_cnt - ls0);
    else pass_cnt++;
  endtask

  task automatic test_step();
    int en0;
    do_load();
    en0 = en_cnt;
    i_halt = 0;
    i_pc = 32'h10;
    mcnt = mcnt + 1;
    push64({i_pc, mcnt});
    send_rx(8'h53);
    wait_idle(500);
    total++;
    if (en_cnt - en0 != 1 || exp_q.size() != 0 || o_busy !== 1'b0)
      $display("FAIL step en=%0d pending=%0d busy=%b exp=1/0/0", en_cnt - en0, exp_q.size(), o_busy);
    else pass_cnt++;
  endtask

  task automatic test_run();
    int en0;
    do_load();
    en0 = en_cnt;
    i_halt = 0;
    i_pc = 32'h8C;
    push64({32'h8C, 32'd37});
    send_rx(8'h52);
    repeat (37) @(posedge clk);
    #1 i_halt = 1;
    #1;
    total++;
    if (o_cpu_enable !== 1'b0) $display("FAIL run_halt_gate got=%b exp=0", o_cpu_enable);
    else pass_cnt++;
    mcnt = 37;
    wait_idle(500);
    total++;
    if (en_cnt - en0 != 37 || exp_q.size() != 0 || o_busy !== 1'b0)
      $display("FAIL run en=%0d pending=%0d busy=%b exp=37/0/0", en_cnt - en0, exp_q.size(), o_busy);
    else pass_cnt++;
  endtask

  task automatic test_halted_step();
    int en0 = en_cnt;
    i_halt = 1;
    i_pc = 32'hCAFE_0004;
    push64({i_pc, mcnt});
    send_rx(8'h53);
    wait_idle(500);
    total++;
    if (en_cnt != en0 || exp_q.size() != 0 || o_busy !== 1'b0)
      $display("FAIL halted_step en=%0d pending=%0d busy=%b exp=0/0/0", en_cnt - en0, exp_q.size(), o_busy);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int en0;
    force dut.cnt = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.cnt;
    @(posedge clk); #1;
    en0 = en_cnt;
    i_halt = 0;
    i_pc = 32'h0000_0200;
    push64({i_pc, 32'h0});
    send_rx(8'h53);
    wait_idle(500);
    total++;
    if (en_cnt - en0 != 1 || exp_q.size() != 0 || o_busy !== 1'b0)
      $display("FAIL wrap en=%0d pending=%0d busy=%b exp=1/0/0", en_cnt - en0, exp_q.size(), o_busy);
    else pass_cnt++;
    mcnt = 0;
  endtask

  task automatic test_reset_mid_dump();
    int n = 0, en0, ls0;
    i_halt = 0;
    i_pc = 32'hA1B2_C3D4;
    push64({i_pc, mcnt + 32'd1});
    send_rx(8'h53);
    do begin @(negedge clk); #1; n++; end while (exp_q.size() > 5 && n < 500);
    total++;
    if (exp_q.size() != 5) $display("FAIL dump_progress pending=%0d exp=5", exp_q.size());
    else pass_cnt++;
    rst = 1;
    #1;
    total++;
    if ({o_tx_start, o_tx_data, o_load_start, o_cpu_enable, o_busy} !== 12'h0)
      $display("FAIL reset_mid_dump got=%b exp=0", {o_tx_start, o_tx_data, o_load_start, o_cpu_enable, o_busy});
    else pass_cnt++;
    exp_q.delete();
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    en0 = en_cnt;
    ls0 = ls_cnt;
    mcnt = 1;
    push64({i_pc, mcnt});
    send_rx(8'h53);
    send_rx(8'h4C);
    @(posedge clk); #1;
    send_rx(8'h52);
    send_rx(8'h00);
    wait_idle(500);
    total++;
    if (en_cnt - en0 != 1 || ls_cnt != ls0 || exp_q.size() != 0 || o_busy !== 1'b0)
      $display("FAIL post_reset_dump en=%0d ls=%0d pending=%0d busy=%b exp=1/0/0/0", en_cnt - en0, ls_cnt - ls0, exp_q.size(), o_busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int en0 = en_cnt;
    i_halt = 0;
    i_pc = 32'h0000_0044;
    for (int k = 0; k < 3; k++) begin
      mcnt = mcnt + 1;
      push64({i_pc, mcnt});
      send_rx(8'h53);
      wait_idle(500);
    end
    total++;
    if (en_cnt - en0 != 3 || exp_q.size() != 0 || o_busy !== 1'b0)
      $display("FAIL back_to_back en=%0d pending=%0d busy=%b exp=3/0/0", en_cnt - en0, exp_q.size(), o_busy);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout total=%0d passed=%0d", total, pass_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_load();
    test_nak();
    test_step();
    test_run();
    test_halted_step();
    test_wrap();
    test_reset_mid_dump();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/debug_cmd_sequencer.md
Name: debug_cmd_sequencer

Overview:
- Top-level command controller of the debug unit. Decodes command bytes from the UART receiver and sequences the instruction-load FSM and the CPU clock-enable for run and single-step.
- Owns the UART transmitter and uses it to return ACK/NAK bytes and the post-execution state dump (PC, cycle count).
- Sits between the UART rx/tx and the load FSM and the pipeline enable.

Parameters:
- UART_BITS, 8, UART data width; only 8 is supported.
- PC_BITS, 32, PC width; sent as 4 bytes, MSB first.
- CYCLE_BITS, 32, executed-cycle counter width; sent as 4 bytes, MSB first.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- i_rx_done  in  1  one-cycle strobe: i_rx_data is valid.
- i_rx_data  in  UART_BITS  received byte.
- i_tx_done  in  1  one-cycle strobe: transmitter finished the current byte.
- o_tx_start  out  1  one-cycle strobe: start sending o_tx_data.
- o_tx_data  out  UART_BITS  byte to transmit; held stable until i_tx_done.
- o_load_start  out  1  one-cycle start pulse to the instruction-load FSM.
- i_load_done  in  1  one-cycle strobe from the load FSM: program written.
- o_cpu_enable  out  1  pipeline clock-enable.
- i_halt  in  1  CPU has executed its halt instruction; level.
- i_pc  in  PC_BITS  current CPU PC.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces state IDLE, cycle_count=0, byte index=0.
- Reset values: all outputs 0, including o_tx_data.
- Commands, decoded only in IDLE on i_rx_done:
  - 0x4C 'L' (load) -> LOAD_START.
  - 0x52 'R' (run) -> RUN.
  - 0x53 'S' (step) -> STEP.
  - any other byte -> REPLY with 0x15 (NAK).
- Bytes received outside IDLE are ignored by this block. During LOAD_WAIT the load FSM consumes them.
- States and transitions:
  - LOAD_START: o_load_start=1 for exactly 1 cycle; cycle_count cleared to 0 -> LOAD_WAIT.
  - LOAD_WAIT: wait for i_load_done -> REPLY with 0x06 (ACK). No timeout.
  - RUN: o_cpu_enable=1 every cycle while i_halt=0; cycle_count+1 per enabled cycle.
    - On the first cycle with i_halt=1: o_cpu_enable=0 that same cycle (combinational gate), no increment, -> DUMP.
    - If i_halt=1 on entry: zero enabled cycles, straight to DUMP.
  - STEP: if i_halt=0, o_cpu_enable=1 for exactly 1 cycle and cycle_count+1; if i_halt=1, enable stays 0. Either way -> DUMP next cycle.
  - DUMP: snapshot {i_pc, cycle_count} into a 64-bit shift register on entry, then send 8 bytes MSB first: PC[31:24] .. PC[7:0], CNT[31:24] .. CNT[7:0].
    - Per byte: 1-cycle o_tx_start with o_tx_data valid, then wait for i_tx_done.
    - The next o_tx_start comes on the cycle after i_tx_done.
    - After the 8th i_tx_done -> IDLE.
  - REPLY: send a single byte using the same tx handshake -> IDLE after i_tx_done.
- o_tx_start never re-asserts before i_tx_done of the previous byte; at most one byte is in flight.
- cycle_count wraps modulo 2^CYCLE_BITS (0xFFFFFFFF+1 -> 0). It is not cleared by run or step, only by load and reset.
- i_rx_done and i_tx_done arriving in the same cycle: the tx handshake proceeds; rx is ignored unless in IDLE.
- Reset mid-operation (e.g. during RUN or a DUMP byte): immediate return to IDLE, o_cpu_enable and o_tx_start drop asynchronously, partial dump is abandoned.
- o_busy = (state != IDLE), combinational from state.

Test Plan:
- Reset, rx 0x4C -> o_load_start high for 1 cycle, o_busy=1. Pulse i_load_done -> o_tx_start with o_tx_data=0x06; after i_tx_done, o_busy=0.
- Rx 0x7A -> single tx byte 0x15; no o_load_start and no o_cpu_enable pulse.
- After load, i_halt=0, i_pc=0x00000010, rx 0x53 -> o_cpu_enable high exactly 1 cycle. Tx sequence 00 00 00 10 00 00 00 01, each byte sent only after the previous i_tx_done.
- After load, rx 0x52, raise i_halt after 37 enabled cycles with i_pc=0x0000008C -> o_cpu_enable low in the halt cycle. Dump 00 00 00 8C 00 00 00 25.
- With i_halt=1, rx 0x53 -> no enable pulse; dump reports the unchanged count. Separately, preload cycle_count=0xFFFFFFFF via run, then step -> count field 00 00 00 00.
- Assert rst during the 3rd dump byte -> outputs 0 immediately. Rx 0x53 after release -> fresh dump starts at byte 0; extra rx bytes sent during the dump are ignored.
